// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
// Shared defaults and helpers for the register-busy scoreboard.
//   SB_NUM_REGS / SB_REGNOBITS / SB_CNT_BITS / SB_NUM_WB / SB_WB_BYPASS :
//     default parameter values for reg_scoreboard and sb_counter.
//   wb_lsb()   : bit offset of writeback port k inside the packed wb_regno bus.
//   dec_bits() : width needed to count how many WB ports hit one register.
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

    localparam int unsigned SB_NUM_REGS  = 32;
    localparam int unsigned SB_REGNOBITS = 5;
    localparam int unsigned SB_CNT_BITS  = 2;
    localparam int unsigned SB_NUM_WB    = 1;
    localparam int unsigned SB_WB_BYPASS = 1;

    // Port k of wb_regno occupies [k*regnobits +: regnobits].
    function automatic int unsigned wb_lsb(input int unsigned port,
                                           input int unsigned regnobits);
        return port * regnobits;
    endfunction

    // Up to num_wb ports may hit one register in a cycle: needs 0..num_wb.
    function automatic int unsigned dec_bits(input int unsigned num_wb);
        return $clog2(num_wb + 1);
    endfunction

endpackage

// File: rtl/sb_counter.sv
// -----------------------------------------------------------------------------
// sb_counter
// Pending-write counter for one architectural register.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   inc       : one new write allocated this cycle
//   dec_cnt   : number of writeback ports retiring this register this cycle
//   count     : registered pending-write count
//   busy      : registered (count != 0)
//   busy_next : combinational (next count != 0), used for the global empty flag
//   underflow : combinational, more retires than registered pending writes
// Decrements beyond the registered count are dropped; the result saturates
// at the counter maximum.
// -----------------------------------------------------------------------------
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_BITS = SB_CNT_BITS,
    parameter int unsigned DEC_BITS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic [DEC_BITS-1:0] dec_cnt,
    output logic [CNT_BITS-1:0] count,
    output logic                busy,
    output logic                busy_next,
    output logic                underflow
);

    localparam int unsigned W = ((CNT_BITS > DEC_BITS) ? CNT_BITS : DEC_BITS) + 1;
    localparam logic [W-1:0] CNT_MAX = W'((1 << CNT_BITS) - 1);

    logic [CNT_BITS-1:0] r_count;
    logic                r_busy;

    logic [W-1:0]        w_cur;
    logic [W-1:0]        w_dec;
    logic [W-1:0]        w_take;
    logic [W-1:0]        w_sum;
    logic [CNT_BITS-1:0] w_next;

    always_comb begin
        w_cur  = W'(r_count);
        w_dec  = W'(dec_cnt);
        // Only as many retires as were actually pending can be applied.
        w_take = (w_dec > w_cur) ? w_cur : w_dec;
        w_sum  = w_cur + W'(inc) - w_take;
        w_next = (w_sum > CNT_MAX) ? CNT_MAX[CNT_BITS-1:0] : w_sum[CNT_BITS-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_busy  <= |w_next;
        end
    end

    assign count     = r_count;
    assign busy      = r_busy;
    assign busy_next = |w_next;
    assign underflow = (w_dec > w_cur);

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Register-busy scoreboard for decode: a saturating pending-write counter per
// architectural register (register 0 untracked), NUM_WB writeback ports and an
// optional same-cycle writeback bypass for read hazards.
//   clk, reset      : clock, asynchronous active-low reset
//   dec_valid       : decode holds a valid instruction
//   dec_use_rs1/rs1 : rs1 read enable and index
//   dec_use_rs2/rs2 : rs2 read enable and index
//   dec_wr_reg/rd   : rd write enable and index
//   flush           : squash the instruction in decode this cycle
//   wb_valid        : per-port writeback strobes
//   wb_regno        : per-port writeback indices, port k at [k*REGNOBITS +: REGNOBITS]
//   stall, issue    : combinational decode handshake
//   busy            : registered per-register (count != 0), bit 0 always 0
//   sb_empty        : registered, no pending writes anywhere
//   err_underflow   : sticky, a writeback hit a register with too few pending writes
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS  = SB_NUM_REGS,
    parameter int unsigned REGNOBITS = SB_REGNOBITS,
    parameter int unsigned CNT_BITS  = SB_CNT_BITS,
    parameter int unsigned NUM_WB    = SB_NUM_WB,
    parameter int unsigned WB_BYPASS = SB_WB_BYPASS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        dec_valid,
    input  logic                        dec_use_rs1,
    input  logic [REGNOBITS-1:0]        dec_rs1,
    input  logic                        dec_use_rs2,
    input  logic [REGNOBITS-1:0]        dec_rs2,
    input  logic                        dec_wr_reg,
    input  logic [REGNOBITS-1:0]        dec_rd,
    input  logic                        flush,
    input  logic [NUM_WB-1:0]           wb_valid,
    input  logic [NUM_WB*REGNOBITS-1:0] wb_regno,
    output logic                        stall,
    output logic                        issue,
    output logic [NUM_REGS-1:0]         busy,
    output logic                        sb_empty,
    output logic                        err_underflow
);

    localparam int unsigned DCW = dec_bits(NUM_WB);
    localparam int unsigned CW  = ((CNT_BITS > DCW) ? CNT_BITS : DCW) + 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    // Per-register state lives in sb_counter cells; index 0 has no cell.
    logic [CNT_BITS-1:0] w_count [1:NUM_REGS-1];
    logic [DCW-1:0]      w_match [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] w_inc;
    logic [NUM_REGS-1:1] w_busy;
    logic [NUM_REGS-1:1] w_busy_next;
    logic [NUM_REGS-1:1] w_uflow;
    logic [NUM_REGS-1:1] w_eff_nz;

    logic w_rs1_hz;
    logic w_rs2_hz;
    logic w_rd_sat;
    logic w_raw;
    logic w_waw_sat;
    logic w_alloc;

    logic r_empty;
    logic r_err;

    // Count writeback hits per register; out-of-range indices match nothing.
    always_comb begin
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            w_match[r] = '0;
            for (int unsigned k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] &&
                    (wb_regno[wb_lsb(k, REGNOBITS) +: REGNOBITS] == REGNOBITS'(r))) begin
                    w_match[r] = w_match[r] + DCW'(1);
                end
            end
        end
    end

    // Source/destination lookup by comparison rather than array indexing,
    // so index 0 and indices >= NUM_REGS fall through as "no hazard".
    always_comb begin
        w_rs1_hz = 1'b0;
        w_rs2_hz = 1'b0;
        w_rd_sat = 1'b0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (dec_rs1 == REGNOBITS'(r)) w_rs1_hz = w_eff_nz[r];
            if (dec_rs2 == REGNOBITS'(r)) w_rs2_hz = w_eff_nz[r];
            if (dec_rd  == REGNOBITS'(r)) w_rd_sat = (w_count[r] == CNT_MAX);
        end
    end

    always_comb begin
        w_raw     = (dec_use_rs1 && w_rs1_hz) || (dec_use_rs2 && w_rs2_hz);
        // Saturation looks at the registered count only: a retire this cycle
        // does not free a slot until the next cycle.
        w_waw_sat = dec_wr_reg && w_rd_sat;
        stall     = dec_valid && (w_raw || w_waw_sat || flush);
        issue     = dec_valid && !stall;
        w_alloc   = issue && dec_wr_reg && (dec_rd != '0);
    end

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
        assign w_inc[g] = w_alloc && (dec_rd == REGNOBITS'(g));

        if (WB_BYPASS != 0) begin : g_byp
            assign w_eff_nz[g] = (CW'(w_count[g]) > CW'(w_match[g]));
        end else begin : g_nobyp
            assign w_eff_nz[g] = |w_count[g];
        end

        sb_counter #(
            .CNT_BITS (CNT_BITS),
            .DEC_BITS (DCW)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (w_inc[g]),
            .dec_cnt   (w_match[g]),
            .count     (w_count[g]),
            .busy      (w_busy[g]),
            .busy_next (w_busy_next[g]),
            .underflow (w_uflow[g])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_empty <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_empty <= ~|w_busy_next;
            r_err   <= r_err | (|w_uflow);
        end
    end

    assign busy          = {w_busy, 1'b0};
    assign sb_empty      = r_empty;
    assign err_underflow = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    localparam int NR   = 24;   // leaves indices 24..31 out of range
    localparam int RB   = 5;
    localparam int CB   = 2;
    localparam int NWB  = 2;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              dec_valid, dec_use_rs1, dec_use_rs2, dec_wr_reg, flush;
    logic [RB-1:0]     dec_rs1, dec_rs2, dec_rd;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*RB-1:0] wb_regno;

    logic [1:0]    o_stall, o_issue, o_empty, o_err;
    logic [NR-1:0] o_busy [2];

    // Instance 0: bypass enabled, instance 1: bypass disabled; same stimulus.
    reg_scoreboard #(.NUM_REGS(NR), .REGNOBITS(RB), .CNT_BITS(CB), .NUM_WB(NWB), .WB_BYPASS(1)) u_dut_byp (
        .clk(clk), .reset(reset), .dec_valid(dec_valid),
        .dec_use_rs1(dec_use_rs1), .dec_rs1(dec_rs1),
        .dec_use_rs2(dec_use_rs2), .dec_rs2(dec_rs2),
        .dec_wr_reg(dec_wr_reg), .dec_rd(dec_rd), .flush(flush),
        .wb_valid(wb_valid), .wb_regno(wb_regno),
        .stall(o_stall[0]), .issue(o_issue[0]), .busy(o_busy[0]),
        .sb_empty(o_empty[0]), .err_underflow(o_err[0])
    );

    reg_scoreboard #(.NUM_REGS(NR), .REGNOBITS(RB), .CNT_BITS(CB), .NUM_WB(NWB), .WB_BYPASS(0)) u_dut_nobyp (
        .clk(clk), .reset(reset), .dec_valid(dec_valid),
        .dec_use_rs1(dec_use_rs1), .dec_rs1(dec_rs1),
        .dec_use_rs2(dec_use_rs2), .dec_rs2(dec_rs2),
        .dec_wr_reg(dec_wr_reg), .dec_rd(dec_rd), .flush(flush),
        .wb_valid(wb_valid), .wb_regno(wb_regno),
        .stall(o_stall[1]), .issue(o_issue[1]), .busy(o_busy[1]),
        .sb_empty(o_empty[1]), .err_underflow(o_err[1])
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Reference model: plain pending-write counts per register, per instance.
    int m_cnt [2][NR];
    bit m_err [2];
    bit e_stall [2];
    bit e_issue [2];

    task automatic m_clear();
        for (int b = 0; b < 2; b++) begin
            m_err[b] = 1'b0;
            for (int r = 0; r < NR; r++) m_cnt[b][r] = 0;
        end
    endtask

    function automatic int nmatch(input int r);
        int n;
        n = 0;
        for (int k = 0; k < NWB; k++)
            if (wb_valid[k] && int'(wb_regno[k*RB +: RB]) == r) n++;
        return n;
    endfunction

    function automatic bit hz(input int b, input int idx);
        int e;
        if (idx == 0 || idx >= NR) return 1'b0;
        e = m_cnt[b][idx];
        if (b == 0) e = e - nmatch(idx);
        return e > 0;
    endfunction

    function automatic bit sat(input int b, input int idx);
        if (idx == 0 || idx >= NR) return 1'b0;
        return m_cnt[b][idx] == CMAX;
    endfunction

    function automatic logic [NR-1:0] m_busy(input int b);
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = (m_cnt[b][r] != 0);
        return v;
    endfunction

    // Check combinational handshake mid-cycle.
    task automatic peek();
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            bit raw, waw;
            raw = (dec_use_rs1 && hz(b, int'(dec_rs1))) || (dec_use_rs2 && hz(b, int'(dec_rs2)));
            waw = dec_wr_reg && sat(b, int'(dec_rd));
            e_stall[b] = dec_valid && (raw || waw || flush);
            e_issue[b] = dec_valid && !e_stall[b];
            chk($sformatf("stall%0d", b), o_stall[b], e_stall[b]);
            chk($sformatf("issue%0d", b), o_issue[b], e_issue[b]);
        end
    endtask

    // Advance the model across the edge and check registered outputs.
    task automatic commit();
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            for (int r = 1; r < NR; r++) begin
                int n, inc;
                n   = nmatch(r);
                inc = (e_issue[b] && dec_wr_reg && int'(dec_rd) == r) ? 1 : 0;
                if (n > m_cnt[b][r]) begin
                    m_err[b] = 1'b1;
                    n = m_cnt[b][r];
                end
                m_cnt[b][r] = m_cnt[b][r] + inc - n;
            end
        end
        #1;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("busy%0d", b), o_busy[b], m_busy(b));
            chk($sformatf("empty%0d", b), o_empty[b], m_busy(b) == '0);
            chk($sformatf("err%0d", b), o_err[b], m_err[b]);
        end
    endtask

    task automatic cyc();
        peek();
        commit();
    endtask

    task automatic idle();
        dec_valid = 0; dec_use_rs1 = 0; dec_rs1 = '0; dec_use_rs2 = 0; dec_rs2 = '0;
        dec_wr_reg = 0; dec_rd = '0; flush = 0; wb_valid = '0; wb_regno = '0;
    endtask

    task automatic dec(input bit v, input bit u1, input int r1, input bit u2, input int r2,
                       input bit wr, input int rd, input bit fl);
        dec_valid = v; dec_use_rs1 = u1; dec_rs1 = RB'(r1); dec_use_rs2 = u2; dec_rs2 = RB'(r2);
        dec_wr_reg = wr; dec_rd = RB'(rd); flush = fl;
    endtask

    task automatic wb(input bit v0, input int r0, input bit v1, input int r1);
        wb_valid = {v1, v0};
        wb_regno = {RB'(r1), RB'(r0)};
    endtask

    // Assert reset between edges and check outputs before the next edge.
    task automatic apply_reset();
        #2;
        idle();
        reset = 1'b0;
        #1;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("rst_busy%0d", b), o_busy[b], '0);
            chk($sformatf("rst_empty%0d", b), o_empty[b], 1);
            chk($sformatf("rst_err%0d", b), o_err[b], 0);
        end
        m_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic int pick_reg();
        if ($urandom % 4 != 0) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, 31));
    endfunction

    function automatic int wb_pick();
        int start, r;
        if ($urandom % 20 == 0) return int'($urandom_range(0, 31));
        start = int'($urandom_range(1, NR - 1));
        for (int i = 0; i < NR - 1; i++) begin
            r = 1 + (start - 1 + i) % (NR - 1);
            if (m_cnt[0][r] > 0) return r;
        end
        return int'($urandom_range(0, 31));
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("init_busy%0d", b), o_busy[b], '0);
            chk($sformatf("init_empty%0d", b), o_empty[b], 1);
            chk($sformatf("init_err%0d", b), o_err[b], 0);
        end
        reset = 1'b1;

        // Writer then dependent reader.
        idle(); dec(1, 0, 0, 0, 0, 1, 5, 0); cyc();
        idle(); dec(1, 1, 5, 0, 0, 0, 0, 0); peek();
        chk("raw_stall", o_stall[0], 1);
        chk("busy5_set", o_busy[0][5], 1);
        commit();

        // Reader with retiring WB in the same cycle.
        idle(); dec(1, 0, 0, 1, 5, 0, 0, 0); wb(1, 5, 0, 0); peek();
        chk("byp_issue", o_issue[0], 1);
        chk("nobyp_stall", o_stall[1], 1);
        commit();
        idle(); dec(1, 0, 0, 1, 5, 0, 0, 0); peek();
        chk("nobyp_retry", o_stall[1], 0);
        commit();
        chk("busy5_clr", o_busy[1][5], 0);

        // Saturation on rd=7.
        for (int i = 0; i < 3; i++) begin
            idle(); dec(1, 0, 0, 0, 0, 1, 7, 0); cyc();
        end
        idle(); dec(1, 0, 0, 0, 0, 1, 7, 0); peek();
        chk("sat_stall", o_stall[0], 1);
        commit();
        wb(1, 7, 0, 0); peek();
        chk("sat_hold", o_stall[0], 1);
        commit();
        idle(); dec(1, 0, 0, 0, 0, 1, 7, 0); peek();
        chk("sat_issue", o_issue[0], 1);
        commit();
        idle(); wb(1, 7, 1, 7); cyc();
        idle(); wb(1, 7, 0, 0); cyc();

        // Flush, rd=0 and out-of-range indices.
        idle(); dec(1, 0, 0, 0, 0, 1, 9, 1); peek();
        chk("flush_issue", o_issue[0], 0);
        commit();
        chk("flush_busy9", o_busy[0][9], 0);
        idle(); dec(1, 0, 0, 0, 0, 1, 0, 0); peek();
        chk("rd0_issue", o_issue[0], 1);
        commit();
        chk("rd0_busy", o_busy[0], '0);
        idle(); dec(1, 1, 28, 0, 0, 1, 30, 0); cyc();
        idle(); wb(1, 26, 1, 0); cyc();
        chk("oob_err", o_err[0], 0);

        // Dual-port retire, then underflow.
        idle(); dec(1, 0, 0, 0, 0, 1, 3, 0); cyc();
        cyc();
        idle(); wb(1, 3, 1, 3); cyc();
        chk("dual_empty", o_empty[0], 1);
        idle(); wb(1, 3, 0, 0); cyc();
        chk("uflow_set", o_err[0], 1);
        idle(); cyc(); cyc();
        chk("uflow_sticky", o_err[0], 1);

        // Asynchronous reset with pending writes.
        apply_reset();
        idle(); dec(1, 0, 0, 0, 0, 1, 4, 0); cyc();
        cyc();
        apply_reset();
        idle(); dec(1, 1, 4, 0, 0, 0, 0, 0); peek();
        chk("post_rst_stall", o_stall[0], 0);
        commit();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) apply_reset();
            idle();
            dec($urandom % 4 != 0, $urandom % 2 == 1, pick_reg(), $urandom % 2 == 1, pick_reg(),
                $urandom % 2 == 1, pick_reg(), $urandom % 16 == 0);
            wb($urandom % 2 == 1, wb_pick(), $urandom % 3 == 0, wb_pick());
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Parametrised register-busy scoreboard for the decode stage.
- Replaces the single-bit in-use vector with a saturating pending-write counter per architectural register, so several writes to the same register can be in flight.
- Supports N writeback ports and an optional same-cycle writeback bypass.
- Sits between decode (source/destination fields) and the FE stall path; WB ports come from the writeback stage(s).

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- REGNOBITS, 5, register index width; must satisfy 2**REGNOBITS >= NUM_REGS.
- CNT_BITS, 2, pending-write counter width; maximum in-flight writes per register is 2**CNT_BITS-1.
- NUM_WB, 1, number of writeback ports (1..4).
- WB_BYPASS, 1, when 1 a writeback that retires the last pending write to a source register clears that hazard in the same cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- dec_valid  in  1  decode holds a valid instruction.
- dec_use_rs1  in  1  instruction reads rs1.
- dec_rs1  in  REGNOBITS  rs1 index.
- dec_use_rs2  in  1  instruction reads rs2.
- dec_rs2  in  REGNOBITS  rs2 index.
- dec_wr_reg  in  1  instruction writes rd.
- dec_rd  in  REGNOBITS  rd index.
- flush  in  1  branch mispredict; squashes the instruction in decode this cycle.
- wb_valid  in  NUM_WB  per-port writeback strobe.
- wb_regno  in  NUM_WB*REGNOBITS  per-port destination index, port k at bits [k*REGNOBITS +: REGNOBITS].
- stall  out  1  decode must hold; combinational.
- issue  out  1  instruction leaves decode this cycle; combinational.
- busy  out  NUM_REGS  bit r = (count[r] != 0); registered.
- sb_empty  out  1  no pending writes anywhere; registered.
- err_underflow  out  1  sticky flag: a writeback hit a register with count 0.

Behaviour:
- Reset (reset==0, asynchronous): all counters = 0, busy = 0, sb_empty = 1, err_underflow = 0. The reset is released synchronously to clk by the top level.
- Effective count eff[r]:
  - WB_BYPASS=1: count[r] minus the number of WB ports this cycle with wb_valid & wb_regno==r, floored at 0.
  - WB_BYPASS=0: count[r].
- Hazards:
  - raw = (dec_use_rs1 & rs1!=0 & eff[rs1]!=0) | (dec_use_rs2 & rs2!=0 & eff[rs2]!=0).
  - waw_sat = dec_wr_reg & rd!=0 & count[rd]==MAX. Saturation uses the registered count, with no bypass.
- stall = dec_valid & (raw | waw_sat | flush).
- issue = dec_valid & ~stall.
- alloc = issue & dec_wr_reg & dec_rd!=0.
- Counter update each cycle, for each r != 0:
  - next = count[r] + (alloc & dec_rd==r) - dec_cnt[r].
  - dec_cnt[r] = number of ports with wb_valid & wb_regno==r, clamped so the result never goes below 0.
- Same-cycle cases:
  - Alloc and retire on the same register: net change applied (e.g. count 1, +1 -1 -> stays 1).
  - Multiple WB ports on the same register: each decrements.
- Underflow: any WB strobe to r with count[r] < matches. Excess decrements are dropped and err_underflow is set; it clears only on reset.
- Index 0 and out-of-range indices (>= NUM_REGS): ignored for tracking, never cause stall or error.
- Flush: blocks issue and allocation only. Already-allocated counters are untouched because issued instructions always reach WB.
- Latency:
  - stall and issue: 0 cycles (combinational from inputs and count).
  - busy and sb_empty: reflect the update 1 cycle later.
- Reset mid-operation: all pending state is discarded immediately; outputs go to their reset values in the same instant.

Decomposition:
- Shared package (define.vh-style header): REGNOBITS, NUM_REGS, CNT_BITS defaults, and the wb_regno port-slice macro.
- One natural sub-module: sb_counter.
  - One saturating up/down counter cell with ports inc, dec_cnt[$clog2(NUM_WB+1)], count, underflow.
  - Instantiated NUM_REGS-1 times via generate.
- Hazard and bypass logic stays in the parent.

Test Plan:
- Reset, then issue ADD rd=5 (dec_wr_reg=1), then the next cycle a reader of rs1=5 with no WB -> stall=1, busy[5]=1, count[5]=1.
- count[5]=1; reader rs2=5 and wb_valid=1/wb_regno=5 in the same cycle:
  - WB_BYPASS=1 -> stall=0, issue=1.
  - WB_BYPASS=0 -> stall=1; next cycle stall=0, busy[5]=0.
- CNT_BITS=2: three writers to rd=7 issue back-to-back -> count=3; a fourth writer -> stall=1 until a WB to 7 arrives, then issue the following cycle.
- NUM_WB=2: count[3]=2; both ports write reg 3 in one cycle -> count[3]=0, sb_empty=1 next cycle; a third WB to 3 -> err_underflow=1 and stays 1.
- flush=1 with a valid writer to rd=9 -> issue=0, count[9] unchanged; a writer with rd=0 -> issue=1, no busy bit set.
- Reset asserted (reset=0) asynchronously with count[4]=2 -> busy=0 and sb_empty=1 before the next edge; a reader of reg 4 after release -> stall=0.
